// File: rtl/bsg_mem_link_wormhole_rr_arbiter.sv
// bsg_mem_link_wormhole_rr_arbiter: packet-aware round-robin split/merge of one wormhole link over num_in_p links.
// Define BSG_MEM_LINK_ARB_STATS_EN to add saturating completed-packet counters.
module bsg_mem_link_wormhole_rr_arbiter #(
  parameter int width_p      = 32,
  parameter int num_in_p     = 2,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        single_v_i,
  input  logic [width_p-1:0]          single_data_i,
  output logic                        single_ready_and_o,
  output logic                        single_v_o,
  output logic [width_p-1:0]          single_data_o,
  input  logic                        single_ready_and_i,
  output logic [num_in_p-1:0]         links_v_o,
  output logic [num_in_p*width_p-1:0] links_data_o,
  input  logic [num_in_p-1:0]         links_ready_and_i,
  input  logic [num_in_p-1:0]         links_v_i,
  input  logic [num_in_p*width_p-1:0] links_data_i,
  output logic [num_in_p-1:0]         links_ready_and_o,
  output logic [15:0]                 stats_out_pkts_o,
  output logic [15:0]                 stats_in_pkts_o
);
  localparam int ptr_w = num_in_p > 1 ? $clog2(num_in_p) : 1;
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(num_in_p - 1);
  typedef enum logic {OIDLE, OBUSY} o_state_e;
  typedef enum logic {IIDLE, IBUSY} i_state_e;
  o_state_e o_state_r, o_state_n;
  i_state_e i_state_r, i_state_n;
  logic [ptr_w-1:0] out_ptr_r, out_ptr_n, in_ptr_r, in_ptr_n, lock_r, lock_n, grant;
  logic [len_width_p-1:0] out_cnt_r, out_cnt_n, in_cnt_r, in_cnt_n, out_len, in_len;
  logic out_hs, in_hs, out_done, in_done, found;
  assign out_len = single_data_i[cord_width_p +: len_width_p];
  assign in_len = single_data_o[cord_width_p +: len_width_p];
  assign links_data_o = {num_in_p{single_data_i}};
  assign single_ready_and_o = ~reset_i & links_ready_and_i[out_ptr_r];
  assign out_hs = single_v_i & single_ready_and_o;
  assign single_data_o = links_data_i[grant*width_p +: width_p];
  assign single_v_o = ~reset_i & found & links_v_i[grant];
  assign in_hs = single_v_o & single_ready_and_i;
  // Descending scan so the first valid link at or after in_ptr_r wins.
  always_comb begin
    grant = lock_r;
    found = (i_state_r == IBUSY);
    if (i_state_r == IIDLE)
      for (int k = num_in_p - 1; k >= 0; k--)
        if (links_v_i[(int'(in_ptr_r) + k) % num_in_p]) begin
          grant = ptr_w'((int'(in_ptr_r) + k) % num_in_p);
          found = 1'b1;
        end
  end
  always_comb begin
    for (int i = 0; i < num_in_p; i++) begin
      links_v_o[i] = ~reset_i & single_v_i & (out_ptr_r == ptr_w'(i));
      links_ready_and_o[i] = ~reset_i & found & single_ready_and_i & (grant == ptr_w'(i));
    end
  end
  always_comb begin
    o_state_n = o_state_r;
    out_cnt_n = out_cnt_r;
    out_done = 1'b0;
    if (out_hs) begin
      out_done = (o_state_r == OIDLE) ? (out_len == '0) : (out_cnt_r == len_width_p'(1));
      out_cnt_n = (o_state_r == OIDLE) ? out_len : out_cnt_r - 1'b1;
      o_state_n = out_done ? OIDLE : OBUSY;
    end
    out_ptr_n = !out_done ? out_ptr_r : (out_ptr_r == last_ptr ? '0 : out_ptr_r + 1'b1);
  end
  always_comb begin
    i_state_n = i_state_r;
    in_cnt_n = in_cnt_r;
    in_ptr_n = in_ptr_r;
    lock_n = lock_r;
    in_done = 1'b0;
    if (in_hs) begin
      in_done = (i_state_r == IIDLE) ? (in_len == '0) : (in_cnt_r == len_width_p'(1));
      in_cnt_n = (i_state_r == IIDLE) ? in_len : in_cnt_r - 1'b1;
      i_state_n = in_done ? IIDLE : IBUSY;
      if (i_state_r == IIDLE) begin
        in_ptr_n = (grant == last_ptr) ? '0 : grant + 1'b1;
        lock_n = grant;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      o_state_r <= OIDLE;
      i_state_r <= IIDLE;
      out_ptr_r <= '0;
      in_ptr_r <= '0;
      lock_r <= '0;
      out_cnt_r <= '0;
      in_cnt_r <= '0;
    end else begin
      o_state_r <= o_state_n;
      i_state_r <= i_state_n;
      out_ptr_r <= out_ptr_n;
      in_ptr_r <= in_ptr_n;
      lock_r <= lock_n;
      out_cnt_r <= out_cnt_n;
      in_cnt_r <= in_cnt_n;
    end
  end
`ifdef BSG_MEM_LINK_ARB_STATS_EN
  logic [15:0] out_pkts_r, in_pkts_r;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_pkts_r <= '0;
      in_pkts_r <= '0;
    end else begin
      if (out_done && out_pkts_r != '1) out_pkts_r <= out_pkts_r + 1'b1;
      if (in_done && in_pkts_r != '1) in_pkts_r <= in_pkts_r + 1'b1;
    end
  end
  assign stats_out_pkts_o = out_pkts_r;
  assign stats_in_pkts_o = in_pkts_r;
`else
  assign stats_out_pkts_o = '0;
  assign stats_in_pkts_o = '0;
`endif
endmodule

// File: tb/tb_bsg_mem_link_wormhole_rr_arbiter.sv
// tb_bsg_mem_link_wormhole_rr_arbiter: directed plus randomized checks against a packet-level model.
module tb_bsg_mem_link_wormhole_rr_arbiter;
  localparam int W = 32;
  localparam int N = 2;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic single_v_i = 1'b0, single_ready_and_o, single_v_o, single_ready_and_i = 1'b0;
  logic [W-1:0] single_data_i = '0, single_data_o;
  logic [N-1:0] links_v_o, links_ready_and_i = '0, links_v_i = '0, links_ready_and_o;
  logic [N*W-1:0] links_data_o, links_data_i = '0;
  logic [15:0] stats_out_pkts_o, stats_in_pkts_o;
  int checks = 0, failures = 0;

  bsg_mem_link_wormhole_rr_arbiter #(.width_p(W), .num_in_p(N), .cord_width_p(8), .len_width_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .single_v_i(single_v_i), .single_data_i(single_data_i), .single_ready_and_o(single_ready_and_o),
    .single_v_o(single_v_o), .single_data_o(single_data_o), .single_ready_and_i(single_ready_and_i),
    .links_v_o(links_v_o), .links_data_o(links_data_o), .links_ready_and_i(links_ready_and_i),
    .links_v_i(links_v_i), .links_data_i(links_data_i), .links_ready_and_o(links_ready_and_o),
    .stats_out_pkts_o(stats_out_pkts_o), .stats_in_pkts_o(stats_in_pkts_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Packet-level model: outbound packet n goes to link n%N; inbound serves whole packets round-robin.
  int opkt = 0, orem = 0, inext = 0, ilock = -1, irem = 0, sout = 0, sin = 0;
  int tgt, g, len;
  bit act, esv, ohs, ihs;
  logic [N-1:0] elv, elr;

  always @(negedge clk) begin
`ifdef BSG_MEM_LINK_ARB_STATS_EN
    chk("m_stats_out", stats_out_pkts_o, 64'(sout));
    chk("m_stats_in", stats_in_pkts_o, 64'(sin));
`else
    chk("m_stats_out", stats_out_pkts_o, 0);
    chk("m_stats_in", stats_in_pkts_o, 0);
`endif
    chk("m_links_data", links_data_o, {N{single_data_i}});
    if (reset_i) begin
      chk("m_rst_links_v", links_v_o, 0);
      chk("m_rst_single_rdy", single_ready_and_o, 0);
      chk("m_rst_single_v", single_v_o, 0);
      chk("m_rst_links_rdy", links_ready_and_o, 0);
      opkt = 0; orem = 0; inext = 0; ilock = -1; irem = 0; sout = 0; sin = 0;
    end else begin
      tgt = opkt % N;
      elv = '0;
      if (single_v_i) elv[tgt] = 1'b1;
      ohs = single_v_i && links_ready_and_i[tgt];
      act = 0;
      g = 0;
      if (ilock >= 0) begin
        g = ilock;
        act = 1;
      end else
        for (int k = 0; k < N; k++)
          if (!act && links_v_i[(inext + k) % N]) begin
            g = (inext + k) % N;
            act = 1;
          end
      esv = act && links_v_i[g];
      elr = '0;
      if (act && single_ready_and_i) elr[g] = 1'b1;
      ihs = esv && single_ready_and_i;
      chk("m_links_v", links_v_o, elv);
      chk("m_single_rdy", single_ready_and_o, links_ready_and_i[tgt]);
      chk("m_single_v", single_v_o, esv);
      chk("m_links_rdy", links_ready_and_o, elr);
      if (esv) chk("m_single_data", single_data_o, links_data_i[g*W +: W]);
      if (ohs) begin
        if (orem == 0) begin
          len = int'(single_data_i[11:8]);
          if (len == 0) begin opkt++; sout++; end
          else orem = len;
        end else begin
          orem--;
          if (orem == 0) begin opkt++; sout++; end
        end
      end
      if (ihs) begin
        if (ilock < 0) begin
          inext = (g + 1) % N;
          len = int'(links_data_i[g*W + 8 +: 4]);
          if (len == 0) sin++;
          else begin ilock = g; irem = len; end
        end else begin
          irem--;
          if (irem == 0) begin ilock = -1; sin++; end
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic sv, input logic [W-1:0] sd, input logic [N-1:0] lr,
                       input logic [N-1:0] lv, input logic [N*W-1:0] ld, input logic sr);
    @(posedge clk);
    #1;
    reset_i = rst; single_v_i = sv; single_data_i = sd; links_ready_and_i = lr;
    links_v_i = lv; links_data_i = ld; single_ready_and_i = sr;
    #1;
  endtask

  localparam logic [W-1:0] A = 32'hA000_0100, B = 32'hB000_0100;
  logic [W-1:0] d, e;
  logic [N-1:0] exp_seq [5];
  logic [W-1:0] exp_dat [5];

  initial begin
    drive(1, 1, 32'h0000_0203, 2'b11, 2'b11, {B, A}, 1);
    chk("rst_links_v", links_v_o, 0);
    chk("rst_single_rdy", single_ready_and_o, 0);
    chk("rst_single_v", single_v_o, 0);
    chk("rst_links_rdy", links_ready_and_o, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++)
      for (int f = 0; f < 3; f++) begin
        drive(0, 1, f == 0 ? 32'h0000_0203 : W'($urandom), 2'b11, 0, 0, 1);
        chk("out_rotation", links_v_o, p % 2 ? 2'b10 : 2'b01);
        chk("out_ready", single_ready_and_o, 1);
      end
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 32'h0000_0303, 2'b01, 0, 0, 1);
      chk("stall_links_v", links_v_o, 2'b10);
      chk("stall_ready", single_ready_and_o, 0);
    end
    for (int f = 0; f < 4; f++) begin
      drive(0, 1, f == 0 ? 32'h0000_0303 : 32'h1234_5678, 2'b11, 0, 0, 1);
      chk("stall_resume", links_v_o, 2'b10);
    end
    for (int p = 0; p < 4; p++) begin
      drive(0, 1, 32'h0000_0000, 2'b11, 0, 0, 1);
      chk("zero_len", links_v_o, p % 2 ? 2'b10 : 2'b01);
    end
    drive(0, 0, 0, 2'b11, 0, 0, 1);
    exp_seq = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    exp_dat = '{A, A, B, B, A};
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 2'b11, {B, A}, 1);
      chk("in_order_rdy", links_ready_and_o, exp_seq[c]);
      chk("in_order_data", single_data_o, exp_dat[c]);
    end
    drive(0, 1, 32'h0000_0300, 2'b11, 2'b11, {B, A}, 1);
    chk("mid_hdr", links_v_o, 2'b01);
    drive(1, 1, 32'hDEAD_BEEF, 2'b11, 2'b11, {B, A}, 1);
    chk("mid_rst_links_v", links_v_o, 0);
    chk("mid_rst_single_rdy", single_ready_and_o, 0);
    chk("mid_rst_single_v", single_v_o, 0);
    chk("mid_rst_links_rdy", links_ready_and_o, 0);
    drive(0, 1, 32'h0000_0000, 2'b11, 2'b11, {B, A}, 1);
    chk("post_rst_out", links_v_o, 2'b01);
    chk("post_rst_in", single_data_o, A);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++)
      drive(0, 1, 32'h0000_00FF, 2'b11, c < 3 ? 2'b01 : 2'b00, {B, 32'hC000_00FF}, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
`ifdef BSG_MEM_LINK_ARB_STATS_EN
    chk("stats_out_5", stats_out_pkts_o, 5);
    chk("stats_in_3", stats_in_pkts_o, 3);
`else
    chk("stats_out_off", stats_out_pkts_o, 0);
    chk("stats_in_off", stats_in_pkts_o, 0);
`endif
    for (int c = 0; c < 3000; c++) begin
      d = W'($urandom);
      d[11:8] = 4'($urandom_range(0, 3));
      e = W'($urandom);
      e[11:8] = 4'($urandom_range(0, 2));
      drive($urandom_range(0, 199) == 0, 1'($urandom), d, 2'($urandom), 2'($urandom),
            {e, W'($urandom) & 32'hFFFF_F3FF}, $urandom_range(0, 3) != 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
